// File: rtl/pipe_chain_if.sv
// Stage-chain bus: upstream payload/handshake, stall/flush controls and
// the register taps returned to forwarding and hazard logic.
interface pipe_chain_if #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 4
);
  logic [WIDTH-1:0]        In;
  logic                    InValid;
  logic [STAGES-1:0]       StallStage;
  logic                    Flush;
  logic                    InReady;
  logic [WIDTH-1:0]        Out;
  logic                    OutValid;
  logic [STAGES*WIDTH-1:0] StageData;
  logic [STAGES-1:0]       StageValid;
  logic [15:0]             BubbleCount;

  modport master (
    output In, InValid, StallStage, Flush,
    input  InReady, Out, OutValid, StageData, StageValid, BubbleCount
  );

  modport slave (
    input  In, InValid, StallStage, Flush,
    output InReady, Out, OutValid, StageData, StageValid, BubbleCount
  );
endinterface

// File: rtl/pipe_chain.sv
// Multi-stage pipeline register chain with per-stage valid, stall with
// bubble insertion, front-end flush and a saturating bubble counter.
module pipe_chain #(
  parameter int unsigned WIDTH       = 64,
  parameter int unsigned STAGES      = 4,
  parameter int unsigned FLUSH_DEPTH = 2
) (
  input  logic         Clock,
  input  logic         nReset,
  pipe_chain_if.slave  bus
);

  logic [WIDTH-1:0]        stData  [STAGES];
  logic [WIDTH-1:0]        nxtData [STAGES];
  logic [STAGES-1:0]       stValid;
  logic [STAGES-1:0]       nxtValid;
  logic [15:0]             bubbleCnt;
  logic [STAGES*WIDTH-1:0] stageDataFlat;
  logic                    stallAny;
  logic                    bubble;
  int unsigned             stallIdx;

  // The furthest-downstream stall decides where the bubble lands.
  always_comb begin
    stallAny = |bus.StallStage;
    stallIdx = 0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      if (bus.StallStage[i]) stallIdx = i;
    end
    bubble = stallAny && (stallIdx < STAGES - 1);
  end

  always_comb begin
    for (int unsigned i = 0; i < STAGES; i++) begin
      nxtData[i]  = stData[i];
      nxtValid[i] = stValid[i];
    end

    // Stage 0 is always at or below any stall point, so a stall means hold.
    if (bus.Flush) begin
      nxtData[0]  = '0;
      nxtValid[0] = 1'b0;
    end else if (!stallAny) begin
      nxtData[0]  = bus.InValid ? bus.In : '0;
      nxtValid[0] = bus.InValid;
    end

    for (int unsigned i = 1; i < STAGES; i++) begin
      if (bus.Flush && (i < FLUSH_DEPTH)) begin
        nxtData[i]  = '0;
        nxtValid[i] = 1'b0;
      end else if (stallAny && (i <= stallIdx)) begin
        nxtData[i]  = stData[i];
        nxtValid[i] = stValid[i];
      end else if (stallAny && (i == stallIdx + 1)) begin
        nxtData[i]  = '0;
        nxtValid[i] = 1'b0;
      end else begin
        nxtData[i]  = stData[i-1];
        nxtValid[i] = stValid[i-1];
      end
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int unsigned i = 0; i < STAGES; i++) stData[i] <= '0;
      stValid   <= '0;
      bubbleCnt <= '0;
    end else begin
      for (int unsigned i = 0; i < STAGES; i++) stData[i] <= nxtData[i];
      stValid <= nxtValid;
      if ((bubble || bus.Flush) && (bubbleCnt != '1)) bubbleCnt <= bubbleCnt + 16'd1;
    end
  end

  always_comb begin
    stageDataFlat = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      stageDataFlat[i*WIDTH +: WIDTH] = stData[i];
    end
  end

  assign bus.InReady     = ~stallAny;
  assign bus.Out         = stData[STAGES-1];
  assign bus.OutValid    = stValid[STAGES-1];
  assign bus.StageData   = stageDataFlat;
  assign bus.StageValid  = stValid;
  assign bus.BubbleCount = bubbleCnt;

endmodule
